dmem_ctrl: RTL and testbench

//  Data-memory stage directly downstream of the single-cycle CPU: consumes data_addr/data_in/
//  mem_read/mem_write, returns data_out. Wraps a word-organised SRAM behind a fixed-latency access
//  FSM and raises stall so the CPU holds its state while an access is in flight.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_ctrl.sv | 136 +++++++++++++
 tb/tb_dmem_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: FSM encoding, default
// reject data and a constant width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Number of bits needed to index 'value' entries (value >= 2).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word-organised synchronous SRAM with a one-cycle registered read.
// The read port samples idx every cycle; a write and a read of the same word
// in one cycle return the old contents.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Write port plus registered read port.
  // NOTE: the storage array has no reset so it maps onto SRAM macros; every
  // state element here uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage behind a single-cycle CPU. Requests are checked for
// conflict, alignment and range in IDLE; accepted ones run through a
// fixed-latency WAIT phase with stall raised, then pulse done in RESP.
// Rejected requests pulse addr_err and never reach the SRAM.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] ERR_DATA    = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        addr_err
);

  localparam int         AW       = clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_e        r_state;
  logic [2:0]    r_cnt;
  logic          r_is_write;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;

  logic [31:0]   w_off;
  logic          w_req;
  logic          w_conflict;
  logic          w_misaligned;
  logic          w_oob;
  logic          w_reject;
  logic [AW-1:0] w_req_idx;
  logic          w_last;
  logic          w_we;
  logic [AW-1:0] w_arr_idx;
  logic [31:0]   w_rdata;

  // Request decode. The subtract wraps addresses below BASE_ADDR to large
  // offsets, so the single range compare catches both ends.
  assign w_off        = data_addr - BASE_ADDR;
  assign w_req        = mem_read | mem_write;
  assign w_conflict   = mem_read & mem_write;
  assign w_misaligned = (data_addr[1:0] != 2'b00);
  assign w_oob        = ((w_off >> 2) >= 32'(DEPTH_WORDS));
  assign w_reject     = w_conflict | w_misaligned | w_oob;
  assign w_req_idx    = w_off[AW+1:2];

  // The access happens on the final WAIT edge. The write is gated by rst_n so
  // a reset landing on that edge abandons the store.
  assign w_last = (r_state == WAIT) && (r_cnt == 3'd0);
  assign w_we   = rst_n && w_last && r_is_write;

  // The SRAM read is one cycle deep: in IDLE it is steered by the incoming
  // address so that even with LATENCY=1 the word is ready at the final WAIT
  // edge; afterwards it follows the latched index.
  assign w_arr_idx = (r_state == IDLE) ? w_req_idx : r_idx;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .idx   (w_arr_idx),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  // Capture the request in IDLE; inputs may change freely once it is accepted.
  // Pure datapath, so it carries no reset.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && w_req) begin
      r_is_write <= mem_write;
      r_idx      <= w_req_idx;
      r_wdata    <= data_in;
    end
  end

  // Access FSM with registered stall/done/addr_err/data_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      data_out <= 32'd0;
      stall    <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_reject) begin
              addr_err <= 1'b1;
              if (mem_read) begin
                data_out <= ERR_DATA;
              end
            end else begin
              r_cnt   <= CNT_INIT;
              stall   <= 1'b1;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            if (!r_is_write) begin
              data_out <= w_rdata;
            end
            stall   <= 1'b0;
            done    <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl. Two instances with different geometry
// (LATENCY 2 at base 0 / 1024 words, LATENCY 1 at base 0x2000 / 16 words) are
// driven one at a time. The driver computes each expected response from a
// word-level memory model and queues it; a negedge monitor pops and compares
// whenever done or addr_err appears.
module tb_dmem_ctrl;

  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam int          D0 = 1024;
  localparam int          L0 = 2;
  localparam logic [31:0] E0 = 32'hDEAD_BEEF;
  localparam logic [31:0] B1 = 32'h0000_2000;
  localparam int          D1 = 16;
  localparam int          L1 = 1;
  localparam logic [31:0] E1 = 32'hBAD0_0BAD;

  localparam logic [1:0] K_DONE = 2'b10;
  localparam logic [1:0] K_ERR  = 2'b01;

  typedef struct {
    int          inst;
    logic [1:0]  kind;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic [1:0]  rst_n_v;
  logic [31:0] addr_v [2];
  logic [31:0] din_v  [2];
  logic [1:0]  rd_v;
  logic [1:0]  wr_v;
  logic [31:0] dout_v [2];
  logic [1:0]  stall_v;
  logic [1:0]  done_v;
  logic [1:0]  err_v;

  int tests;
  int fails;

  exp_t        sb_q [$];
  logic [31:0] model_mem [longint];
  logic [31:0] exp_dout [2];
  bit          dout_known [2];
  int          stall_cnt [2];

  dmem_ctrl #(
    .BASE_ADDR (B0), .DEPTH_WORDS (D0), .LATENCY (L0), .ERR_DATA (E0)
  ) u_dut0 (
    .clk (clk), .rst_n (rst_n_v[0]), .data_addr (addr_v[0]), .data_in (din_v[0]),
    .mem_read (rd_v[0]), .mem_write (wr_v[0]), .data_out (dout_v[0]),
    .stall (stall_v[0]), .done (done_v[0]), .addr_err (err_v[0])
  );

  dmem_ctrl #(
    .BASE_ADDR (B1), .DEPTH_WORDS (D1), .LATENCY (L1), .ERR_DATA (E1)
  ) u_dut1 (
    .clk (clk), .rst_n (rst_n_v[1]), .data_addr (addr_v[1]), .data_in (din_v[1]),
    .mem_read (rd_v[1]), .mem_write (wr_v[1]), .data_out (dout_v[1]),
    .stall (stall_v[1]), .done (done_v[1]), .addr_err (err_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] base_of(input int u);
    return (u == 0) ? B0 : B1;
  endfunction

  function automatic int depth_of(input int u);
    return (u == 0) ? D0 : D1;
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? L0 : L1;
  endfunction

  function automatic logic [31:0] err_of(input int u);
    return (u == 0) ? E0 : E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model: decide accept/reject from the address rules, update the
  // word memory and the expected data_out, and describe the response.
  function automatic exp_t model_req(input int u, input bit rd, input bit wr,
                                     input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] off;
    longint      key;
    off    = addr - base_of(u);
    e.inst = u;
    if ((rd && wr) || (addr % 4 != 0) || (longint'(off / 4) >= longint'(depth_of(u)))) begin
      e.kind = K_ERR;
      if (rd) begin
        exp_dout[u]   = err_of(u);
        dout_known[u] = 1'b1;
      end
    end else begin
      e.kind = K_DONE;
      key    = longint'(u) * 100000 + longint'(off / 4);
      if (wr) begin
        model_mem[key] = wdata;
      end else if (model_mem.exists(key)) begin
        exp_dout[u]   = model_mem[key];
        dout_known[u] = 1'b1;
      end else begin
        dout_known[u] = 1'b0;
      end
    end
    e.chk  = dout_known[u];
    e.data = exp_dout[u];
    return e;
  endfunction

  task automatic wait_idle(input int u);
    int guard;
    guard = 0;
    while ((stall_v[u] || done_v[u]) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Issue one request and hold it for n_acc acceptances (n_acc=2 keeps the
  // request present across RESP). After the last acceptance the request is
  // dropped and address/data are scrambled.
  task automatic do_req(input int u, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata, input int n_acc);
    exp_t e;
    int   cyc;
    int   scr_at;
    bit   got;
    wait_idle(u);
    addr_v[u] = addr;
    din_v[u]  = wdata;
    rd_v[u]   = rd;
    wr_v[u]   = wr;
    for (int k = 0; k < n_acc; k++) begin
      e = model_req(u, rd, wr, addr, wdata);
      sb_q.push_back(e);
      scr_at = (k == 0) ? 1 : 2;
      cyc    = 0;
      got    = 1'b0;
      while (!got && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (k == n_acc - 1 && cyc == scr_at) begin
          rd_v[u]   = 1'b0;
          wr_v[u]   = 1'b0;
          addr_v[u] = $urandom;
          din_v[u]  = $urandom;
        end
        got = done_v[u] | err_v[u];
      end
      if (!got) begin
        tests++;
        fails++;
        $display("FAIL resp_timeout: inst %0d addr %h no done/addr_err within 20 cycles", u, addr);
      end else if (k == 0) begin
        check("resp_latency", cyc, (e.kind == K_ERR) ? 1 : lat_of(u) + 1);
      end else begin
        check("held_req_latency", cyc, lat_of(u) + 2);
      end
    end
    rd_v[u] = 1'b0;
    wr_v[u] = 1'b0;
  endtask

  task automatic check_outputs_zero(input int u, input string tag);
    check({tag, "_data_out"}, dout_v[u], 32'd0);
    check({tag, "_stall"}, {31'd0, stall_v[u]}, 32'd0);
    check({tag, "_done"}, {31'd0, done_v[u]}, 32'd0);
    check({tag, "_addr_err"}, {31'd0, err_v[u]}, 32'd0);
  endtask

  // Store accepted, then reset in its first WAIT cycle: the store must be lost.
  task automatic abort_store(input int u, input logic [31:0] addr, input logic [31:0] wdata);
    wait_idle(u);
    addr_v[u] = addr;
    din_v[u]  = wdata;
    wr_v[u]   = 1'b1;
    @(negedge clk);
    check("abort_in_wait_stall", {31'd0, stall_v[u]}, 32'd1);
    wr_v[u]    = 1'b0;
    rst_n_v[u] = 1'b0;
    @(negedge clk);
    check_outputs_zero(u, "abort_in_reset");
    rst_n_v[u] = 1'b1;
    @(negedge clk);
    check_outputs_zero(u, "abort_after_release");
    exp_dout[u]   = 32'd0;
    dout_known[u] = 1'b1;
  endtask

  task automatic rand_op(input int u);
    int          r;
    int          sel;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] b;
    b  = base_of(u);
    r  = $urandom_range(0, 9);
    rd = (r <= 4) || (r == 9);
    wr = (r >= 5);
    sel = $urandom_range(0, 11);
    if (sel <= 6)       a = b + 32'(4 * $urandom_range(0, 15));
    else if (sel == 7)  a = b + 32'(4 * (depth_of(u) - 1));
    else if (sel == 8)  a = b + 32'(4 * depth_of(u)) + 32'(4 * $urandom_range(0, 3));
    else if (sel == 9)  a = b - 32'(4 * $urandom_range(1, 4));
    else if (sel == 10) a = (b + 32'(4 * $urandom_range(0, 15))) | 32'($urandom_range(1, 3));
    else                a = 32'hFFFF_FFFF;
    do_req(u, rd, wr, a, $urandom, 1);
  endtask

  // Monitor: every done/addr_err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n_v[u]) begin
        stall_cnt[u] = 0;
      end else if (done_v[u] || err_v[u]) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: inst %0d done=%b addr_err=%b, nothing outstanding",
                   u, done_v[u], err_v[u]);
        end else begin
          e = sb_q.pop_front();
          check("resp_inst", u, e.inst);
          check("resp_kind", {30'd0, done_v[u], err_v[u]}, {30'd0, e.kind});
          if (e.chk) check("data_out", dout_v[u], e.data);
          check("stall_cycles", stall_cnt[u], (e.kind == K_DONE) ? lat_of(u) : 0);
          check("stall_low_at_resp", {31'd0, stall_v[u]}, 32'd0);
        end
        stall_cnt[u] = 0;
      end else if (stall_v[u]) begin
        stall_cnt[u]++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n_v = 2'b00;
    rd_v    = 2'b00;
    wr_v    = 2'b00;
    for (int u = 0; u < 2; u++) begin
      addr_v[u]     = 32'd0;
      din_v[u]      = 32'd0;
      exp_dout[u]   = 32'd0;
      dout_known[u] = 1'b1;
      stall_cnt[u]  = 0;
    end
    repeat (3) @(negedge clk);
    check_outputs_zero(0, "reset0");
    check_outputs_zero(1, "reset1");
    rst_n_v = 2'b11;
    @(negedge clk);

    // Store then load the same word.
    do_req(0, 1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1);
    do_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1);
    // Misaligned load, end-of-program address.
    do_req(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 1);
    do_req(0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1);
    // Range boundary: one past the end, then the last word.
    do_req(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 1);
    do_req(0, 1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 1);
    do_req(0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 1);
    // Conflicting request must not disturb memory.
    do_req(0, 1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 1);
    do_req(0, 1'b1, 1'b1, 32'h0000_0020, 32'h9999_9999, 1);
    do_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1);
    // Reset during WAIT abandons the store.
    do_req(0, 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 1);
    abort_store(0, 32'h0000_0040, 32'h1234_5678);
    do_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1);
    // Request held across RESP is accepted again in the following IDLE.
    do_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 2);

    // LATENCY=1 instance with a non-zero base.
    do_req(1, 1'b0, 1'b1, 32'h0000_2008, 32'h5555_AAAA, 1);
    do_req(1, 1'b1, 1'b0, 32'h0000_2008, 32'h0, 2);
    do_req(1, 1'b1, 1'b0, 32'h0000_1FFC, 32'h0, 1);
    do_req(1, 1'b0, 1'b1, 32'h0000_203C, 32'h7777_0000, 1);
    do_req(1, 1'b1, 1'b0, 32'h0000_203C, 32'h0, 1);
    do_req(1, 1'b1, 1'b0, 32'h0000_2040, 32'h0, 1);
    abort_store(1, 32'h0000_2008, 32'hFFFF_0000);
    do_req(1, 1'b1, 1'b0, 32'h0000_2008, 32'h0, 1);

    for (int n = 0; n < 150; n++) rand_op(0);
    for (int n = 0; n < 150; n++) rand_op(1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
